// File: rtl/match_window_counter.sv
// match_window_counter: counts rising edges of a detector level output over
// fixed windows of WINDOW clock cycles and hands each closed-window count to a
// valid/ready consumer, with a threshold alarm and a sticky overflow flag.
//
// state | meaning
// IDLE  | not counting; waits for en=1 to start a fresh window
// RUN   | window open; timer advances each cycle, matches accumulate
module match_window_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y,
    input  logic             en,
    input  logic             clr_ovf,
    input  logic             cnt_ready,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] cnt_data,
    output logic             alarm,
    output logic             overflow
);

    localparam int unsigned       TMR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WINDOW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] count;
    logic             y_q;

    logic             match;
    logic             close;
    logic             accept;
    logic             alarm_hit;
    logic [CNT_W-1:0] count_inc;

    // A match is a rising edge of y, so a long high level counts once.
    assign match     = y & ~y_q;
    // Saturating update; also the count reported when the window closes.
    assign count_inc = (match && (count != '1)) ? count + CNT_W'(1) : count;
    // An en=0 edge aborts even on the last cycle, so a close needs en=1.
    assign close     = (state == RUN) && en && (timer == TMR_LAST);
    // The slot is free if empty or being drained in this same cycle.
    assign accept    = ~cnt_valid | cnt_ready;
    assign alarm_hit = (32'(count_inc) >= THRESH);

    // Delay y by one cycle for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

    // Window sequencing: state, cycle timer and running match count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        timer <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        timer <= '0;
                        count <= '0;
                    end else if (close) begin
                        timer <= '0;
                        count <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                        count <= count_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    count <= '0;
                end
            endcase
        end
    end

    // Result slot, alarm and overflow; all registered, one cycle after close.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
            alarm     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (close) begin
                alarm <= alarm_hit;
                if (accept) begin
                    cnt_valid <= 1'b1;
                    cnt_data  <= count_inc;
                end
            end else if (cnt_valid && cnt_ready) begin
                cnt_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear request leaves the flag set.
            if (close && !accept) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_match_window_counter.sv
// Self-checking bench for match_window_counter: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_match_window_counter;

    localparam int WINDOW = 16;
    localparam int CNT_W  = 8;
    localparam int THRESH = 3;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             y, en, clr_ovf, cnt_ready;
    logic             cnt_valid, alarm, overflow;
    logic [CNT_W-1:0] cnt_data;

    logic             y2, en2, clr2, rdy2;
    logic             cnt_valid2, alarm2, overflow2;
    logic [1:0]       cnt_data2;

    int errors = 0;
    int checks = 0;

    // model state
    bit m_run;
    int m_pos;
    int m_cnt;
    bit m_prev_y;
    bit m_valid;
    int m_data;
    bit m_alarm;
    bit m_ovf;

    match_window_counter #(.WINDOW(WINDOW), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .y(y), .en(en), .clr_ovf(clr_ovf),
        .cnt_ready(cnt_ready), .cnt_valid(cnt_valid), .cnt_data(cnt_data),
        .alarm(alarm), .overflow(overflow)
    );

    match_window_counter #(.WINDOW(16), .CNT_W(2), .THRESH(3)) dut_sat (
        .clk(clk), .reset(reset), .y(y2), .en(en2), .clr_ovf(clr2),
        .cnt_ready(rdy2), .cnt_valid(cnt_valid2), .cnt_data(cnt_data2),
        .alarm(alarm2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_cnt = 0; m_prev_y = 0;
        m_valid = 0; m_data = 0; m_alarm = 0; m_ovf = 0;
    endtask

    // One clock of the reference behaviour, using the inputs seen at the edge.
    task automatic model_step();
        int  ev;
        int  c;
        bit  closed;
        bit  set_ovf;
        if (!reset) begin
            model_reset();
            return;
        end
        ev = (y && !m_prev_y) ? 1 : 0;
        closed = 0; set_ovf = 0; c = 0;
        if (!m_run) begin
            if (en) begin m_run = 1; m_pos = 0; m_cnt = 0; end
        end else if (!en) begin
            m_run = 0;
        end else begin
            c = m_cnt + ev;
            if (c > MAXC) c = MAXC;
            if (m_pos == WINDOW - 1) begin
                closed = 1; m_pos = 0; m_cnt = 0;
            end else begin
                m_pos = m_pos + 1; m_cnt = c;
            end
        end
        if (closed) begin
            m_alarm = (c >= THRESH);
            if (!m_valid || cnt_ready) begin m_valid = 1; m_data = c; end
            else set_ovf = 1;
        end else if (m_valid && cnt_ready) begin
            m_valid = 0;
        end
        if (set_ovf) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        m_prev_y = y;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic start_clean();
        reset = 0; y = 0; en = 0; clr_ovf = 0; cnt_ready = 0;
        y2 = 0; en2 = 0; clr2 = 0; rdy2 = 0;
        tick();
        reset = 1;
    endtask

    // Drives one full window (pattern bit t is y during RUN cycle t).
    task automatic run_window(input logic [15:0] pat);
        for (int t = 0; t < WINDOW; t++) begin
            y = pat[t];
            tick();
            checks++;
            if ({cnt_valid, cnt_data, alarm, overflow} !== {m_valid, 8'(m_data), m_alarm, m_ovf})
                begin errors++; $display("FAIL window t=%0d: got v=%0b d=%0d a=%0b o=%0b expected v=%0b d=%0d a=%0b o=%0b",
                    t, cnt_valid, cnt_data, alarm, overflow, m_valid, m_data, m_alarm, m_ovf); end
        end
        y = 0;
    endtask

    task automatic test_reset();
        reset = 0; cnt_ready = 0; clr_ovf = 0;
        for (int i = 0; i < 6; i++) begin
            y = 1'($urandom); en = 1'($urandom);
            tick();
            checks++;
            if ({cnt_valid, cnt_data, alarm, overflow} !== 11'd0) begin
                errors++; $display("FAIL reset_hold: got %0h expected 0", {cnt_valid, cnt_data, alarm, overflow});
            end
        end
        reset = 1; y = 0; en = 1;
        for (int i = 0; i <= 16; i++) begin
            tick();
            checks++;
            if (cnt_valid !== (i == 16)) begin
                errors++; $display("FAIL reset_latency i=%0d: got valid=%0b expected %0b", i, cnt_valid, (i == 16));
            end
        end
        checks++;
        if ({cnt_data, alarm, overflow} !== 10'd0) begin
            errors++; $display("FAIL reset_first_window: got d=%0d a=%0b o=%0b expected 0 0 0", cnt_data, alarm, overflow);
        end
    endtask

    task automatic test_count_alarm();
        start_clean();
        cnt_ready = 1; en = 1;
        tick();
        run_window(16'b1000_0000_0010_0100);
        checks++;
        if ({cnt_valid, cnt_data, alarm} !== {1'b1, 8'd3, 1'b1}) begin
            errors++; $display("FAIL count_alarm: got v=%0b d=%0d a=%0b expected 1 3 1", cnt_valid, cnt_data, alarm);
        end
        tick();
        checks++;
        if (cnt_valid !== 1'b0) begin
            errors++; $display("FAIL count_one_cycle: got valid=%0b expected 0", cnt_valid);
        end
    endtask

    task automatic test_level();
        start_clean();
        cnt_ready = 1; en = 1;
        tick();
        run_window(16'b0001_1111_1111_1000);
        checks++;
        if ({cnt_valid, cnt_data, alarm} !== {1'b1, 8'd1, 1'b0}) begin
            errors++; $display("FAIL level_once: got v=%0b d=%0d a=%0b expected 1 1 0", cnt_valid, cnt_data, alarm);
        end
    endtask

    task automatic test_backpressure();
        start_clean();
        cnt_ready = 0; en = 1;
        tick();
        run_window(16'h0012);
        checks++;
        if ({cnt_valid, cnt_data, alarm, overflow} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
            errors++; $display("FAIL bp_first: got v=%0b d=%0d a=%0b o=%0b expected 1 2 0 0", cnt_valid, cnt_data, alarm, overflow);
        end
        clr_ovf = 1;
        run_window(16'h00AA);
        clr_ovf = 0;
        checks++;
        if ({cnt_valid, cnt_data, alarm, overflow} !== {1'b1, 8'd2, 1'b1, 1'b1}) begin
            errors++; $display("FAIL bp_drop: got v=%0b d=%0d a=%0b o=%0b expected 1 2 1 1", cnt_valid, cnt_data, alarm, overflow);
        end
        en = 0;
        tick();
        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        checks++;
        if ({cnt_valid, cnt_data, overflow} !== {1'b1, 8'd2, 1'b0}) begin
            errors++; $display("FAIL bp_clear: got v=%0b d=%0d o=%0b expected 1 2 0", cnt_valid, cnt_data, overflow);
        end
        cnt_ready = 1;
        tick();
        checks++;
        if (cnt_valid !== 1'b0) begin
            errors++; $display("FAIL bp_transfer: got valid=%0b expected 0", cnt_valid);
        end
    endtask

    task automatic test_abort();
        start_clean();
        cnt_ready = 1; en = 1;
        tick();
        for (int t = 0; t < 8; t++) begin
            y = (t == 1 || t == 4);
            tick();
        end
        y = 0; en = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (cnt_valid !== 1'b0) begin
                errors++; $display("FAIL abort_no_valid i=%0d: got valid=%0b expected 0", i, cnt_valid);
            end
        end
        en = 1;
        tick();
        run_window(16'h0040);
        checks++;
        if ({cnt_valid, cnt_data, alarm} !== {1'b1, 8'd1, 1'b0}) begin
            errors++; $display("FAIL abort_restart: got v=%0b d=%0d a=%0b expected 1 1 0", cnt_valid, cnt_data, alarm);
        end
    endtask

    task automatic test_random();
        start_clean();
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 40) != 0);
            y         = ($urandom_range(0, 2) == 0);
            cnt_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if ({cnt_valid, cnt_data, alarm, overflow} !== {m_valid, 8'(m_data), m_alarm, m_ovf})
                begin errors++; $display("FAIL random i=%0d: got v=%0b d=%0d a=%0b o=%0b expected v=%0b d=%0d a=%0b o=%0b",
                    i, cnt_valid, cnt_data, alarm, overflow, m_valid, m_data, m_alarm, m_ovf); end
        end
        en = 0; y = 0; clr_ovf = 0;
    endtask

    task automatic test_saturation();
        start_clean();
        rdy2 = 0; en2 = 1; y2 = 0;
        tick();
        for (int t = 0; t < 16; t++) begin
            y2 = ((t % 2) == 0) && (t < 10);
            tick();
        end
        y2 = 0;
        checks++;
        if ({cnt_valid2, cnt_data2, alarm2} !== {1'b1, 2'd3, 1'b1}) begin
            errors++; $display("FAIL saturate: got v=%0b d=%0d a=%0b expected 1 3 1", cnt_valid2, cnt_data2, alarm2);
        end
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset = 0;
        #1;
        checks++;
        if ({cnt_valid2, cnt_data2, alarm2, overflow2} !== 5'd0) begin
            errors++; $display("FAIL async_reset: got %0h expected 0", {cnt_valid2, cnt_data2, alarm2, overflow2});
        end
        checks++;
        if ({cnt_valid, cnt_data, alarm, overflow} !== 11'd0) begin
            errors++; $display("FAIL async_reset_main: got %0h expected 0", {cnt_valid, cnt_data, alarm, overflow});
        end
        model_reset();
        en2 = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        model_reset();
        reset = 0; y = 0; en = 0; clr_ovf = 0; cnt_ready = 0;
        y2 = 0; en2 = 0; clr2 = 0; rdy2 = 0;
        #1;
        test_reset();
        test_count_alarm();
        test_level();
        test_backpressure();
        test_abort();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
